mem64_16_writer: RTL
====================

// Module: mem64_16_writer
// PURPOSE
//  Write-back end of the 8x8 block path: holds one 8x8 block of DW-bit words and streams it to SRAM.
//  A producer fills the block buffer through a random-access load port. On start, the block goes out
//  row-major (row 0 col 0 .. row 7 col 7) as 64 single-word SRAM writes from a latched base address.
//  It mirrors the 64-word block reader on the SRAM read side.
// PARAMETERS
//  AW  18  SRAM word-address width
//  DW  16  data word width
// PORTS
//  clock    in   1   single clock; all state changes on posedge
//  reset    in   1   synchronous, active-high reset
//  ld_en    in   1   load-port write strobe for the block buffer
//  ld_row   in   3   load-port row index
//  ld_col   in   3   load-port column index
//  ld_data  in   DW  load-port data
//  start    in   1   begin streaming the buffered block (level sampled in IDLE only)
//  base     in   AW  SRAM start address, sampled with start
//  w_ready  in   1   SRAM accepts the presented word this cycle
//  w_en     out  1   SRAM write request
//  w_addr   out  AW  SRAM write address
//  w_data   out  DW  SRAM write data
//  busy     out  1   high in RUN and DONE
//  done     out  1   one-cycle pulse after the 64th word is accepted
// BEHAVIOUR
//  - Reset: state=IDLE, idx=0, base_q=0. w_en=0, busy=0, done=0, w_addr=0, w_data=0.
//    Reset does not clear the block buffer; its contents are undefined until loaded.
//  - Buffer: 64 x DW registers, indexed [row][col].
//    - In IDLE, ld_en writes ld_data to [ld_row][ld_col] at posedge.
//    - In RUN/DONE, ld_en is ignored, so the buffer stays frozen during a transfer.
//  - Counter idx is 6 bits: row=idx[5:3], col=idx[2:0].
//  - FSM states and transitions:
//    - IDLE: start=1 latches base_q<=base and idx<=0, next RUN. ld_en in the same cycle as start still writes.
//    - RUN: w_en=1, w_addr=base_q+idx (mod 2^AW), w_data=buf[idx[5:3]][idx[2:0]].
//      - w_ready=1: word accepted, idx<=idx+1.
//      - w_ready=1 with idx==63: next DONE, idx wraps to 0.
//      - w_ready=0: stall. idx, w_addr and w_data hold and w_en stays 1.
//    - DONE: done=1, w_en=0, next IDLE unconditionally.
//  - Outputs in IDLE and DONE: w_addr and w_data drive 0.
//  - Outputs are decoded combinationally from state, idx, base_q and the buffer. No output registers.
//  - Latency: first w_en is the cycle after start. With no stalls, done asserts exactly 65 cycles after start.
//    Each stall cycle adds one.
//  - start while busy is ignored; no queuing.
//  - Address addition wraps: base_q=2^AW-2 writes ..FFFE, ..FFFF, 0, 1, ...
//  - Reset mid-transfer: at the next posedge go to IDLE with outputs at reset values. The partial write is not resumed.
// TESTING
//  T1 Load buf[r][c]=16'h0100*r+c; start with base=18'h00100, w_ready=1 -> 64 writes, one per cycle.
//     Addresses 0x00100..0x0013F, data 0x0000,0x0001..0x0707 row-major. done at cycle 65 after start, busy falls after it.
//  T2 Same as T1, with w_ready=0 on cycles 3-5 and 40 of RUN -> words held stable while stalled, no duplicates or skips.
//     done at cycle 69.
//  T3 base=18'h3FFFE -> first addresses 0x3FFFE, 0x3FFFF, 0x00000; last address 0x0003D.
//  T4 During RUN, pulse ld_en to [0][0]=16'hDEAD and start=1 -> written data unchanged.
//     No restart; exactly 64 writes and one done.
//  T5 Assert reset at RUN word 20 -> w_en=0 next cycle, busy=0, no done.
//     A later start streams all 64 words from the (unchanged) buffer.
//  T6 Back-to-back: reassert start in the cycle after DONE -> new transfer starts with a new base.
//     Exactly one idle cycle appears between the two transfers' w_en bursts.

Source files
------------

// File: rtl/mem64_16_writer.sv
`default_nettype none
// ============================================================================
// Module   : mem64_16_writer
// Brief    : Buffers one 8x8 block of DW-bit words and streams it row-major
//            to SRAM as 64 single-word writes from a latched base address.
// Revision : 1.0
// ============================================================================
module mem64_16_writer #(
    parameter int AW = 18,
    parameter int DW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ld_en,
    input  logic [2:0]    ld_row,
    input  logic [2:0]    ld_col,
    input  logic [DW-1:0] ld_data,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic          w_ready,
    output logic          w_en,
    output logic [AW-1:0] w_addr,
    output logic [DW-1:0] w_data,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0] C_LAST_IDX = 6'd63;

    state_t        r_state;
    state_t        w_state_next;
    logic [5:0]    r_idx;
    logic [5:0]    w_idx_next;
    logic [AW-1:0] r_base;
    logic [AW-1:0] w_base_next;
    logic [DW-1:0] r_buf [0:7][0:7];

    // Buffer is not reset; loads are accepted only while idle so it stays frozen mid-transfer.
    always_ff @(posedge clock) begin
        if (r_state == S_IDLE && ld_en) begin
            r_buf[ld_row][ld_col] <= ld_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_base  <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_base  <= w_base_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_base_next  = r_base;
        w_en         = 1'b0;
        w_addr       = '0;
        w_data       = '0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_base_next  = base;
                    w_idx_next   = '0;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_en   = 1'b1;
                busy   = 1'b1;
                w_addr = r_base + {{(AW-6){1'b0}}, r_idx};
                w_data = r_buf[r_idx[5:3]][r_idx[2:0]];
                if (w_ready) begin
                    // idx wraps 63 -> 0 on the final accepted word
                    w_idx_next = r_idx + 6'd1;
                    if (r_idx == C_LAST_IDX) begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
